// File: rtl/intpol_pkg.sv
// Shared constants for the interpolator data movers: FSM state codes and
// default widths used by the memory-to-FIFO source and its helpers.
package intpol_pkg;

   localparam int DATA_WIDTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF  = 7;
   localparam int DEPTH_WIDTH_DEF = 8;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/source_skid_buf.sv
// Two-entry in-order buffer between the memory return path and the FIFO
// write port. The parent's credit scheme guarantees push never hits a full
// buffer and pop never hits an empty one.
module source_skid_buf
   import intpol_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] ent0_r;
   logic [DATA_WIDTH-1:0] ent1_r;
   logic                  wr_ptr_r;
   logic                  rd_ptr_r;
   logic [1:0]            occ_r;

   // Write the incoming word into the slot selected by the write pointer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent0_r   <= '0;
         ent1_r   <= '0;
         wr_ptr_r <= 1'b0;
      end else if (push) begin
         if (wr_ptr_r) begin
            ent1_r <= push_data;
         end else begin
            ent0_r <= push_data;
         end
         wr_ptr_r <= ~wr_ptr_r;
      end
   end

   // Advance the read pointer when the head is consumed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_r <= 1'b0;
      end else if (pop) begin
         rd_ptr_r <= ~rd_ptr_r;
      end
   end

   // Track occupancy; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ_r <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Present the oldest entry and the occupancy to the parent.
   always_comb begin
      occ_o = occ_r;
      if (rd_ptr_r) begin
         head_o = ent1_r;
      end else begin
         head_o = ent0_r;
      end
   end

endmodule

// File: rtl/mem_fifo_source.sv
// Streams data_depth words from a synchronous-read memory, addresses 0
// upward, into a downstream FIFO while honouring its full flag. Reads are
// issued only when the skid buffer is guaranteed room for the returning word,
// so backpressure never loses or duplicates data.
module mem_fifo_source
   import intpol_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start_i,
   input  logic [DEPTH_WIDTH-1:0] data_depth,
   input  logic                   full_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   output logic                   mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0]  mem_addr_o,
   output logic                   fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]  fifo_data_o,
   output logic                   busy_o,
   output logic                   done_o
);

   logic [1:0]             state_r;
   logic [1:0]             state_nxt_s;
   logic [DEPTH_WIDTH-1:0] depth_r;
   logic [DEPTH_WIDTH-1:0] rd_cnt_r;
   logic [DEPTH_WIDTH-1:0] wr_cnt_r;
   logic [DEPTH_WIDTH-1:0] wr_cnt_inc_s;
   logic                   inflight_r;
   logic [1:0]             occ_s;
   logic [DATA_WIDTH-1:0]  head_s;
   logic                   accept_s;
   logic                   rd_go_s;
   logic                   wr_go_s;
   logic                   last_wr_s;
   logic [2:0]             used_s;
   logic [2:0]             avail_s;

   source_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .push      (inflight_r),
      .push_data (mem_data_i),
      .pop       (wr_go_s),
      .occ_o     (occ_s),
      .head_o    (head_s)
   );

   // Read/write decisions; credit > 0 is evaluated as (2 + pop) > (occ + inflight).
   always_comb begin
      accept_s     = (state_r == IDLE) && start_i;
      wr_go_s      = (state_r == STREAM) && (occ_s != 2'd0) && !full_i;
      used_s       = {1'b0, occ_s} + {2'b00, inflight_r};
      avail_s      = 3'd2 + {2'b00, wr_go_s};
      rd_go_s      = (state_r == STREAM) && (rd_cnt_r < depth_r) && (avail_s > used_s);
      wr_cnt_inc_s = wr_cnt_r + DEPTH_WIDTH'(1'b1);
      last_wr_s    = wr_go_s && (wr_cnt_inc_s == depth_r);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               if (data_depth == '0) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = STREAM;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         STREAM: begin
            if (last_wr_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = STREAM;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs; everything decodes from reset registers so reset forces all to 0.
   always_comb begin
      mem_rd_en_o  = 1'b0;
      mem_addr_o   = '0;
      fifo_wr_en_o = 1'b0;
      fifo_data_o  = '0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      case (state_r)
         STREAM: begin
            busy_o       = 1'b1;
            mem_rd_en_o  = rd_go_s;
            mem_addr_o   = rd_cnt_r[ADDR_WIDTH-1:0];
            fifo_wr_en_o = wr_go_s;
            if (occ_s != 2'd0) begin
               fifo_data_o = head_s;
            end else begin
               fifo_data_o = '0;
            end
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   // Latch the depth on an accepted start; counters restart from zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         depth_r  <= '0;
         rd_cnt_r <= '0;
         wr_cnt_r <= '0;
      end else if (accept_s) begin
         depth_r  <= data_depth;
         rd_cnt_r <= '0;
         wr_cnt_r <= '0;
      end else begin
         if (rd_go_s) begin
            rd_cnt_r <= rd_cnt_r + DEPTH_WIDTH'(1'b1);
         end
         if (wr_go_s) begin
            wr_cnt_r <= wr_cnt_inc_s;
         end
      end
   end

   // A read issued this cycle returns data next cycle; reset drops it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= rd_go_s;
      end
   end

endmodule
